rx_lane_sync_ctrl: RTL and testbench

//   Link-level controller for the receive lane. Sits after the serial-to-parallel deserializer in the clk_4f domain.

---
 rtl/rx_link_pkg.sv | 20 ++
 rtl/rx_lane_sync_ctrl_sat_counter.sv | 31 +++
 rtl/rx_lane_sync_ctrl.sv | 173 +++++++++++++++++
 tb/tb_rx_lane_sync_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_link_pkg.sv
// Shared definitions for the receive-lane link controller.
//   COMMA_BC        idle/comma byte used for sync acquisition
//   rx_state_e      controller state encoding
//   DEF_SYNC_COUNT  default number of clean commas needed to acquire sync
//   DEF_LOSS_COUNT  default run of symbol errors that declares loss of sync
package rx_link_pkg;

  localparam logic [7:0] COMMA_BC = 8'hBC;

  localparam int DEF_SYNC_COUNT = 4;
  localparam int DEF_LOSS_COUNT = 3;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_SEARCH   = 2'd1,
    ST_ACTIVE   = 2'd2,
    ST_LOST     = 2'd3
  } rx_state_e;

endpackage

// File: rtl/rx_lane_sync_ctrl_sat_counter.sv
// Saturating up-counter (module sat_counter).
//   clk    in   1      clock, posedge
//   rst_n  in   1      asynchronous active-low reset, clears count
//   inc    in   1      increment by one, holds at all-ones
//   clr    in   1      synchronous clear, wins over inc
//   cnt    out  WIDTH  current count
module sat_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/rx_lane_sync_ctrl.sv
// Receive-lane link controller: enables the deserializer, acquires sync on
// a run of clean comma bytes, qualifies payload bytes, and restarts the
// deserializer when a run of symbol errors signals loss of sync.
// Optional statistics counters are built when RX_STATS_EN is defined.
//   clk_4f     in   1   byte clock
//   reset      in   1   asynchronous active-low reset
//   lane_en    in   1   lane enable; low forces DISABLED
//   data_in    in   8   byte from deserializer
//   sym_err    in   1   data_in is corrupt this cycle
//   des_en     out  1   deserializer run enable
//   data_rx    out  8   registered payload byte
//   valid_rx   out  1   data_rx holds a payload byte
//   active     out  1   lane in sync
//   sync_lost  out  1   one-cycle pulse on loss of sync
//   byte_cnt   out  16  payload bytes accepted (RX_STATS_EN)
//   err_cnt    out  8   sym_err cycles seen in ACTIVE (RX_STATS_EN)
//   dbg_state  out  2   current controller state
// Handshake: valid_rx is a qualifier only; there is no back-pressure, and
// data_rx/valid_rx follow data_in by exactly one clk_4f while ACTIVE.
module rx_lane_sync_ctrl
  import rx_link_pkg::*;
#(
  parameter int SYNC_COUNT = DEF_SYNC_COUNT,
  parameter int LOSS_COUNT = DEF_LOSS_COUNT
) (
  input  logic        clk_4f,
  input  logic        reset,
  input  logic        lane_en,
  input  logic [7:0]  data_in,
  input  logic        sym_err,
  output logic        des_en,
  output logic [7:0]  data_rx,
  output logic        valid_rx,
  output logic        active,
  output logic        sync_lost,
`ifdef RX_STATS_EN
  output logic [15:0] byte_cnt,
  output logic [7:0]  err_cnt,
`endif
  output rx_state_e   dbg_state
);

  rx_state_e  r_state;
  logic       r_des_en;
  logic [7:0] r_data_rx;
  logic       r_valid_rx;
  logic       r_active;
  logic       r_sync_lost;

  logic [3:0] w_bc_cnt;
  logic [3:0] w_err_run;
  logic       w_clean_comma;
  logic       w_sync_hit;
  logic       w_loss_hit;
  logic       w_payload;
  logic       w_bc_inc;
  logic       w_bc_clr;
  logic       w_err_inc;
  logic       w_err_clr;

  assign w_clean_comma = (data_in == COMMA_BC) && !sym_err;

  // The comma that brings bc_cnt to SYNC_COUNT (or the error that brings
  // err_run to LOSS_COUNT) triggers the transition on this same edge.
  assign w_sync_hit = (r_state == ST_SEARCH) && w_clean_comma &&
                      (({1'b0, w_bc_cnt} + 5'd1) == 5'(SYNC_COUNT));
  assign w_loss_hit = (r_state == ST_ACTIVE) && sym_err &&
                      (({1'b0, w_err_run} + 5'd1) >= 5'(LOSS_COUNT));

  assign w_payload = (r_state == ST_ACTIVE) && lane_en &&
                     (data_in != COMMA_BC) && !sym_err;

  // Counters are held at zero outside their own state, so they are
  // already clear whenever SEARCH or ACTIVE is entered.
  assign w_bc_inc  = (r_state == ST_SEARCH) && w_clean_comma;
  assign w_bc_clr  = !w_bc_inc || w_sync_hit || !lane_en;
  assign w_err_inc = (r_state == ST_ACTIVE) && sym_err;
  assign w_err_clr = !w_err_inc || w_loss_hit || !lane_en;

  sat_counter #(.WIDTH(4)) u_bc_cnt (
    .clk   (clk_4f),
    .rst_n (reset),
    .inc   (w_bc_inc),
    .clr   (w_bc_clr),
    .cnt   (w_bc_cnt)
  );

  sat_counter #(.WIDTH(4)) u_err_run (
    .clk   (clk_4f),
    .rst_n (reset),
    .inc   (w_err_inc),
    .clr   (w_err_clr),
    .cnt   (w_err_run)
  );

  // Outputs are registered for the state being entered; lane_en=0 wins
  // over any sync/loss event and suppresses the sync_lost pulse.
  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_DISABLED;
      r_des_en    <= 1'b0;
      r_data_rx   <= 8'h00;
      r_valid_rx  <= 1'b0;
      r_active    <= 1'b0;
      r_sync_lost <= 1'b0;
    end else begin
      r_des_en    <= 1'b0;
      r_data_rx   <= 8'h00;
      r_valid_rx  <= 1'b0;
      r_active    <= 1'b0;
      r_sync_lost <= 1'b0;
      if (!lane_en) begin
        r_state <= ST_DISABLED;
      end else begin
        case (r_state)
          ST_DISABLED: begin
            r_state  <= ST_SEARCH;
            r_des_en <= 1'b1;
          end
          ST_SEARCH: begin
            r_des_en <= 1'b1;
            if (w_sync_hit) begin
              r_state  <= ST_ACTIVE;
              r_active <= 1'b1;
            end
          end
          ST_ACTIVE: begin
            if (w_loss_hit) begin
              r_state     <= ST_LOST;
              r_sync_lost <= 1'b1;
            end else begin
              r_des_en   <= 1'b1;
              r_active   <= 1'b1;
              r_data_rx  <= data_in;
              r_valid_rx <= w_payload;
            end
          end
          default: begin
            r_state  <= ST_SEARCH;
            r_des_en <= 1'b1;
          end
        endcase
      end
    end
  end

`ifdef RX_STATS_EN
  // Statistics clear only on reset.
  sat_counter #(.WIDTH(16)) u_byte_cnt (
    .clk   (clk_4f),
    .rst_n (reset),
    .inc   (w_payload),
    .clr   (1'b0),
    .cnt   (byte_cnt)
  );

  sat_counter #(.WIDTH(8)) u_err_cnt (
    .clk   (clk_4f),
    .rst_n (reset),
    .inc   (w_err_inc),
    .clr   (1'b0),
    .cnt   (err_cnt)
  );
`endif

  assign des_en    = r_des_en;
  assign data_rx   = r_data_rx;
  assign valid_rx  = r_valid_rx;
  assign active    = r_active;
  assign sync_lost = r_sync_lost;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_rx_lane_sync_ctrl.sv
module tb_rx_lane_sync_ctrl;
  import rx_link_pkg::*;

  logic        clk_4f;
  logic        reset;
  logic        lane_en;
  logic [7:0]  data_in;
  logic        sym_err;
  logic        des_en;
  logic [7:0]  data_rx;
  logic        valid_rx;
  logic        active;
  logic        sync_lost;
`ifdef RX_STATS_EN
  logic [15:0] byte_cnt;
  logic [7:0]  err_cnt;
`endif
  rx_state_e   dbg_state;

  int total;
  int bad;
  logic [8:0] exp_q[$];

  rx_lane_sync_ctrl dut (
    .clk_4f    (clk_4f),
    .reset     (reset),
    .lane_en   (lane_en),
    .data_in   (data_in),
    .sym_err   (sym_err),
    .des_en    (des_en),
    .data_rx   (data_rx),
    .valid_rx  (valid_rx),
    .active    (active),
    .sync_lost (sync_lost),
`ifdef RX_STATS_EN
    .byte_cnt  (byte_cnt),
    .err_cnt   (err_cnt),
`endif
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk_4f = 1'b0;
  always #5 clk_4f = ~clk_4f;

  // driver tasks: inputs change and outputs are sampled 1 ns after posedge
  task automatic cycle();
    @(posedge clk_4f);
    #1;
  endtask

  task automatic drive(input logic [7:0] d, input logic e);
    data_in = d;
    sym_err = e;
    cycle();
  endtask

  task automatic acquire();
    lane_en = 1'b1;
    drive(8'h00, 1'b0);
    for (int i = 0; i < 4; i++) drive(8'hBC, 1'b0);
  endtask

  // scoreboard: expected {valid_rx, data_rx} pushed at drive time,
  // popped and compared after the DUT's one-cycle latency
  task automatic send_payload(input logic [7:0] d, input logic e);
    logic [8:0] exp;
    exp_q.push_back({(d != 8'hBC) && !e, d});
    drive(d, e);
    exp = exp_q.pop_front();
    total++;
    if ({valid_rx, data_rx} !== exp) begin
      $display("FAIL payload: got valid=%0b data=%02h, want valid=%0b data=%02h",
               valid_rx, data_rx, exp[8], exp[7:0]);
      bad++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; lane_en = 1'b0; data_in = 8'h00; sym_err = 1'b0;
    cycle(); cycle();
    total++;
    if ({des_en, data_rx, valid_rx, active, sync_lost} !== 12'h000 ||
        dbg_state !== ST_DISABLED) begin
      $display("FAIL reset_outputs: got %03h state %0d, want 000 state 0",
               {des_en, data_rx, valid_rx, active, sync_lost}, dbg_state);
      bad++;
    end
    reset = 1'b1;
    cycle();
    total++;
    if (des_en !== 1'b0) begin
      $display("FAIL disabled_des_en: got %0b want 0", des_en);
      bad++;
    end
  endtask

  task automatic test_acquire();
    lane_en = 1'b1;
    drive(8'h00, 1'b0);
    total++;
    if (des_en !== 1'b1 || dbg_state !== ST_SEARCH) begin
      $display("FAIL search_entry: des_en=%0b state=%0d, want 1/1", des_en, dbg_state);
      bad++;
    end
    for (int i = 0; i < 4; i++) begin
      drive(8'hBC, 1'b0);
      total++;
      if (active !== (i == 3) || valid_rx !== 1'b0) begin
        $display("FAIL acquire_comma%0d: active=%0b valid=%0b, want %0b/0",
                 i, active, valid_rx, i == 3);
        bad++;
      end
    end
    send_payload(8'h5A, 1'b0);
    for (int i = 0; i < 6; i++) send_payload(8'($urandom_range(0, 255)), 1'b0);
    send_payload(8'hBC, 1'b0);
    send_payload(8'h33, 1'b1);
    send_payload(8'h34, 1'b0);
  endtask

  task automatic test_loss();
    // two errors then a clean byte: no loss
    send_payload(8'h01, 1'b1);
    send_payload(8'h02, 1'b1);
    send_payload(8'h03, 1'b0);
    total++;
    if (active !== 1'b1 || sync_lost !== 1'b0) begin
      $display("FAIL no_loss_2err: active=%0b sync_lost=%0b, want 1/0", active, sync_lost);
      bad++;
    end
    send_payload(8'h04, 1'b1);
    send_payload(8'h05, 1'b1);
    drive(8'h06, 1'b1);
    total++;
    if ({sync_lost, des_en, active, valid_rx, data_rx} !== 12'h800 ||
        dbg_state !== ST_LOST) begin
      $display("FAIL loss_cycle: got %03h state %0d, want 800 state 3",
               {sync_lost, des_en, active, valid_rx, data_rx}, dbg_state);
      bad++;
    end
    drive(8'h00, 1'b0);
    total++;
    if (sync_lost !== 1'b0 || des_en !== 1'b1 || active !== 1'b0 ||
        dbg_state !== ST_SEARCH) begin
      $display("FAIL after_loss: sync_lost=%0b des_en=%0b active=%0b state=%0d, want 0/1/0/1",
               sync_lost, des_en, active, dbg_state);
      bad++;
    end
  endtask

  task automatic test_broken_run();
    logic [7:0] seq [8];
    seq = '{8'hBC, 8'hBC, 8'hBC, 8'h11, 8'hBC, 8'hBC, 8'hBC, 8'hBC};
    for (int i = 0; i < 8; i++) begin
      drive(seq[i], 1'b0);
      total++;
      if (active !== (i == 7) || valid_rx !== 1'b0) begin
        $display("FAIL broken_run%0d: active=%0b valid=%0b, want %0b/0",
                 i, active, valid_rx, i == 7);
        bad++;
      end
    end
    send_payload(8'hC3, 1'b0);
  endtask

  task automatic test_disable_priority();
    send_payload(8'h10, 1'b1);
    send_payload(8'h11, 1'b1);
    lane_en = 1'b0;
    drive(8'h12, 1'b1);
    total++;
    if ({sync_lost, des_en, active, valid_rx, data_rx} !== 12'h000 ||
        dbg_state !== ST_DISABLED) begin
      $display("FAIL disable_priority: got %03h state %0d, want 000 state 0",
               {sync_lost, des_en, active, valid_rx, data_rx}, dbg_state);
      bad++;
    end
    drive(8'hBC, 1'b0);
    total++;
    if (sync_lost !== 1'b0 || des_en !== 1'b0) begin
      $display("FAIL disable_hold: sync_lost=%0b des_en=%0b, want 0/0", sync_lost, des_en);
      bad++;
    end
  endtask

  task automatic test_async_reset();
    acquire();
    send_payload(8'h77, 1'b0);
    data_in = 8'h78;
    #2;
    reset = 1'b0;
    #1;
    total++;
    if ({des_en, data_rx, valid_rx, active, sync_lost} !== 12'h000) begin
      $display("FAIL async_reset: got %03h want 000",
               {des_en, data_rx, valid_rx, active, sync_lost});
      bad++;
    end
    cycle();
    reset = 1'b1;
    lane_en = 1'b0;
    drive(8'h00, 1'b0);
    acquire();
    total++;
    if (active !== 1'b1) begin
      $display("FAIL reacquire: active=%0b want 1", active);
      bad++;
    end
    send_payload(8'h5A, 1'b0);
  endtask

`ifdef RX_STATS_EN
  task automatic test_stats();
    // counters were cleared by the reset in test_async_reset; subtract
    // what that task counted afterwards (one payload byte)
    logic [15:0] base;
    base = 16'd1;
    for (int i = 0; i < 10; i++) send_payload(8'($urandom_range(0, 8'hBB)), 1'b0);
    send_payload(8'hBC, 1'b1);
    send_payload(8'hBC, 1'b0);
    send_payload(8'hBC, 1'b1);
    send_payload(8'hBC, 1'b0);
    total++;
    if (byte_cnt !== base + 16'd10 || err_cnt !== 8'd2) begin
      $display("FAIL stats: byte_cnt=%0d err_cnt=%0d, want %0d/2",
               byte_cnt, err_cnt, base + 16'd10);
      bad++;
    end
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_acquire();
    test_loss();
    test_broken_run();
    test_disable_priority();
    test_async_reset();
`ifdef RX_STATS_EN
    test_stats();
`endif
    total++;
    if (exp_q.size() != 0) begin
      $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size());
      bad++;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
